// File: rtl/alu_seq.sv
// Multi-cycle MIPS-style ALU: single-cycle logic/arith/shift ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), behind valid/ready handshakes.
module alu_seq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   alu_control,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_result,
    output logic [N-1:0] hi,
    output logic         zero,
    output logic         div0,
    output logic         illegal
);

    localparam int SHW = $clog2(N);
    localparam logic [SHW-1:0] LAST = SHW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD  = 4'd2,  OP_NOR  = 4'd3,
        OP_XOR  = 4'd4,  OP_DIVU = 4'd5,  OP_SUB  = 4'd6,  OP_SLT  = 4'd7,
        OP_MULU = 4'd9,  OP_SLL  = 4'd10, OP_SRL  = 4'd13, OP_SLTU = 4'd14,
        OP_SRA  = 4'd15
    } op_t;

    state_t         state, state_nxt;
    logic [SHW-1:0] cnt;
    logic           op_is_mul;
    logic [N-1:0]   opnd;     // multiplicand for MULU, divisor for DIVU
    logic [N-1:0]   hi_acc;   // partial product high half / partial remainder
    logic [N-1:0]   lo_acc;   // multiplier bits / dividend-quotient bits

    logic           accept;
    logic           is_multi;
    logic [N-1:0]   sc_result;
    logic [N-1:0]   sc_hi;
    logic           sc_div0;
    logic           sc_illegal;

    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N:0]     div_trial;
    logic [N-1:0]   hi_nxt;
    logic [N-1:0]   lo_nxt;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // NOTE: every variable driven in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sc_result  = '0;
        sc_hi      = '0;
        sc_div0    = 1'b0;
        sc_illegal = 1'b0;
        is_multi   = 1'b0;
        case (alu_control)
            OP_AND:  sc_result = A & B;
            OP_OR:   sc_result = A | B;
            OP_ADD:  sc_result = A + B;
            OP_NOR:  sc_result = ~(A | B);
            OP_XOR:  sc_result = A ^ B;
            OP_SUB:  sc_result = A - B;
            OP_SLT:  sc_result = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: sc_result = {{(N-1){1'b0}}, (A < B)};
            OP_SLL:  sc_result = A << B[SHW-1:0];
            OP_SRL:  sc_result = A >> B[SHW-1:0];
            OP_SRA:  sc_result = $signed(A) >>> B[SHW-1:0];
            OP_MULU: is_multi  = 1'b1;
            OP_DIVU: begin
                // Divide by zero short-circuits the iteration entirely.
                if (B == '0) begin
                    sc_result = '1;
                    sc_hi     = A;
                    sc_div0   = 1'b1;
                end else begin
                    is_multi  = 1'b1;
                end
            end
            default: sc_illegal = 1'b1;
        endcase
    end

    // One iteration step of either the shift-add multiply or the restoring divide.
    assign mul_sum   = {1'b0, hi_acc} + (lo_acc[0] ? {1'b0, opnd} : '0);
    assign div_shift = {hi_acc, lo_acc[N-1]};
    assign div_trial = div_shift - {1'b0, opnd};

    always_comb begin
        hi_nxt = '0;
        lo_nxt = '0;
        if (op_is_mul) begin
            hi_nxt = mul_sum[N:1];
            lo_nxt = {mul_sum[0], lo_acc[N-1:1]};
        end else if (div_trial[N]) begin
            hi_nxt = div_shift[N-1:0];
            lo_nxt = {lo_acc[N-2:0], 1'b0};
        end else begin
            hi_nxt = div_trial[N-1:0];
            lo_nxt = {lo_acc[N-2:0], 1'b1};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = is_multi ? BUSY : DONE;
            BUSY:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            op_is_mul  <= 1'b0;
            opnd       <= '0;
            hi_acc     <= '0;
            lo_acc     <= '0;
            alu_result <= '0;
            hi         <= '0;
            zero       <= 1'b0;
            div0       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt       <= '0;
                        op_is_mul <= (alu_control == OP_MULU);
                        opnd      <= (alu_control == OP_MULU) ? A : B;
                        hi_acc    <= '0;
                        lo_acc    <= (alu_control == OP_MULU) ? B : A;
                        if (!is_multi) begin
                            alu_result <= sc_result;
                            hi         <= sc_hi;
                            zero       <= (sc_result == '0);
                            div0       <= sc_div0;
                            illegal    <= sc_illegal;
                        end
                    end
                end
                BUSY: begin
                    cnt    <= cnt + 1'b1;
                    hi_acc <= hi_nxt;
                    lo_acc <= lo_nxt;
                    if (cnt == LAST) begin
                        alu_result <= lo_nxt;
                        hi         <= hi_nxt;
                        zero       <= (lo_nxt == '0);
                        div0       <= 1'b0;
                        illegal    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
